// File: rtl/vga_text_writer.sv
// ---------------------------------------------------------------------------
// vga_text_writer
//
// Purpose:
//   Write-port controller for an 80x30 character text buffer. It takes an
//   ASCII byte stream over a valid/ready handshake and keeps a row/column
//   cursor. It interprets control codes (CR, LF, BS, FF and optionally TAB).
//   It sequences two blank-fill engines: a full-screen clear and a
//   single-row clear. Its output is one registered write per cycle toward
//   the buffer (waddr/din/write_en).
//
// Ports:
//   wclk        in   buffer write clock
//   rst         in   synchronous active-high reset
//   s_data      in   incoming character byte
//   s_valid     in   s_data valid
//   s_ready     out  byte accepted this cycle when s_valid is also high
//   waddr       out  buffer write address (registered)
//   din         out  buffer write data (registered)
//   write_en    out  buffer write strobe (registered)
//   cursor_addr out  row*COLS+col (registered)
//   busy        out  a clear engine is running
//
// Configuration:
//   TEXT_TAB_EN  when defined, 0x09 advances the column to the next multiple
//                of 8. A tab that runs off the row does a line advance.
//                When undefined, 0x09 is consumed and ignored.
// ---------------------------------------------------------------------------
module vga_text_writer #(
  parameter int                COLS   = 80,
  parameter int                ROWS   = 30,
  parameter int                ADDR_W = 12,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] BLANK  = 8'h20
) (
  input  logic              wclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] din,
  output logic              write_en,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CELLS = COLS * ROWS;

  localparam logic [DATA_W-1:0] CH_BS    = DATA_W'('h08);
  localparam logic [DATA_W-1:0] CH_LF    = DATA_W'('h0A);
  localparam logic [DATA_W-1:0] CH_FF    = DATA_W'('h0C);
  localparam logic [DATA_W-1:0] CH_CR    = DATA_W'('h0D);
  localparam logic [DATA_W-1:0] CH_SP    = DATA_W'('h20);
  localparam logic [DATA_W-1:0] CH_TILDE = DATA_W'('h7E);
`ifdef TEXT_TAB_EN
  localparam logic [DATA_W-1:0] CH_TAB   = DATA_W'('h09);
`endif

  typedef enum logic [1:0] {
    IDLE,
    CLR_ROW,
    CLR_ALL
  } state_t;

  state_t            state_q,   state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ROW_W-1:0]  row_q,     row_d;
  logic [COL_W-1:0]  col_q,     col_d;
  logic [ADDR_W-1:0] waddr_q,   waddr_d;
  logic [DATA_W-1:0] din_q,     din_d;
  logic              we_q,      we_d;
  logic [ADDR_W-1:0] cursor_q,  cursor_d;
  logic              advance;
  logic              accept;
  logic              printable;
`ifdef TEXT_TAB_EN
  int                tab_col;
`endif

  // The product is formed at full integer width and then truncated to the
  // buffer address width.
  function automatic logic [ADDR_W-1:0] cell_addr(input int r, input int c);
    return ADDR_W'(r * COLS + c);
  endfunction

  assign s_ready     = (state_q == IDLE) & ~rst;
  assign busy        = (state_q != IDLE);
  assign waddr       = waddr_q;
  assign din         = din_q;
  assign write_en    = we_q;
  assign cursor_addr = cursor_q;

  assign accept    = s_valid & s_ready;
  assign printable = (s_data >= CH_SP) && (s_data <= CH_TILDE);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    waddr_d   = waddr_q;
    din_d     = din_q;
    we_d      = 1'b0;
    advance   = 1'b0;
`ifdef TEXT_TAB_EN
    tab_col   = 0;
`endif

    case (state_q)
      CLR_ALL: begin
        we_d    = 1'b1;
        waddr_d = clr_cnt_q;
        din_d   = BLANK;
        if (clr_cnt_q == ADDR_W'(CELLS - 1)) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
          row_d     = '0;
          col_d     = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end

      CLR_ROW: begin
        // row_q already holds the newly entered row.
        we_d    = 1'b1;
        waddr_d = cell_addr(int'(row_q), 0) + clr_cnt_q;
        din_d   = BLANK;
        if (clr_cnt_q == ADDR_W'(COLS - 1)) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end

      default: begin
        if (accept) begin
          if (printable) begin
            we_d    = 1'b1;
            waddr_d = cursor_q;
            din_d   = s_data;
            if (col_q == COL_W'(COLS - 1)) begin
              advance = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            case (s_data)
              CH_CR: col_d = '0;
              CH_LF: advance = 1'b1;
              CH_BS: begin
                // At column 0 a backspace does nothing. It never wraps back
                // to the previous row.
                if (col_q != '0) begin
                  col_d   = col_q - COL_W'(1);
                  we_d    = 1'b1;
                  waddr_d = cursor_q - ADDR_W'(1);
                  din_d   = BLANK;
                end
              end
              CH_FF: begin
                row_d     = '0;
                col_d     = '0;
                clr_cnt_d = '0;
                state_d   = CLR_ALL;
              end
`ifdef TEXT_TAB_EN
              CH_TAB: begin
                tab_col = (int'(col_q) | 7) + 1;
                if (tab_col >= COLS) begin
                  advance = 1'b1;
                end else begin
                  col_d = COL_W'(tab_col);
                end
              end
`endif
              default: ;
            endcase
          end
        end
      end
    endcase

    // Line advance: the new row is wiped rather than scrolled. The buffer
    // behaves like a typewriter that wraps from the bottom back to the top.
    if (advance) begin
      col_d     = '0;
      row_d     = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
      clr_cnt_d = '0;
      state_d   = CLR_ROW;
    end

    cursor_d = cell_addr(int'(row_d), int'(col_d));
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q   <= CLR_ALL;
      clr_cnt_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      waddr_q   <= '0;
      din_q     <= '0;
      we_q      <= 1'b0;
      cursor_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      waddr_q   <= waddr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      cursor_q  <= cursor_d;
    end
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// ---------------------------------------------------------------------------
// tb_vga_text_writer
//
// Self-checking bench for vga_text_writer. It runs in this order:
//   1. Directed reset and clear checks.
//   2. A table of single-byte vectors.
//   3. Hand-written sequences for line wrap, screen wrap, tab and reset
//      during a clear.
//   4. A randomized byte stream. A screen/cursor model predicts the final
//      screen contents and the cursor after every byte.
// TEXT_TAB_EN selects the tab expectations.
// ---------------------------------------------------------------------------
module tb_vga_text_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        wclk = 1'b0;
  logic        rst  = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [11:0] waddr;
  logic [7:0]  din;
  logic        write_en;
  logic [11:0] cursor_addr;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  vga_text_writer dut (
    .wclk        (wclk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .waddr       (waddr),
    .din         (din),
    .write_en    (write_en),
    .cursor_addr (cursor_addr),
    .busy        (busy)
  );

  always #5 wclk = ~wclk;

  // Write monitor: records every buffer write, mid-cycle after the edge.
  int         la[$];
  int         ld[$];
  logic [7:0] dut_mem [CELLS];

  always begin
    @(posedge wclk);
    #2;
    if (write_en === 1'b1) begin
      la.push_back(int'(waddr));
      ld.push_back(int'(din));
      if (int'(waddr) < CELLS) dut_mem[waddr] = din;
    end
  end

  // Behavioural screen model.
  logic [7:0] scr [CELLS];
  int         m_row = 0;
  int         m_col = 0;

  task automatic model_advance();
    m_col = 0;
    m_row = (m_row + 1) % ROWS;
    for (int c = 0; c < COLS; c++) scr[m_row * COLS + c] = 8'h20;
  endtask

  task automatic model_byte(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      scr[m_row * COLS + m_col] = ch;
      if (m_col == COLS - 1) model_advance();
      else m_col++;
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h0A) begin
      model_advance();
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        scr[m_row * COLS + m_col] = 8'h20;
      end
    end else if (ch == 8'h0C) begin
      m_row = 0;
      m_col = 0;
      for (int a = 0; a < CELLS; a++) scr[a] = 8'h20;
    end
`ifdef TEXT_TAB_EN
    else if (ch == 8'h09) begin
      int nc;
      nc = ((m_col / 8) + 1) * 8;
      if (nc >= COLS) model_advance();
      else m_col = nc;
    end
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge. Returns at the negedge following the acceptance edge.
  task automatic send_byte(input logic [7:0] ch);
    int n;
    n = 0;
    while (s_ready !== 1'b1 && n < 6000) begin
      @(negedge wclk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, expected 1", s_ready, n);
    end
    s_data  = ch;
    s_valid = 1'b1;
    @(negedge wclk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 6000) begin
      @(negedge wclk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  // Checks that writes from index base onward are exactly n blanks at
  // consecutive addresses starting at start_addr.
  task automatic check_blank_run(input string name, input int base, input int start_addr, input int n);
    int errs;
    int got;
    errs = 0;
    got  = la.size() - base;
    chk({name, "_count"}, got, n);
    for (int i = 0; i < n && i < got; i++) begin
      if (la[base + i] != start_addr + i || ld[base + i] != 32'h20) errs++;
    end
    chk({name, "_seq_errors"}, errs, 0);
  endtask

  typedef struct {
    logic [7:0]  ch;
    logic        exp_we;
    logic [11:0] exp_addr;
    logic [7:0]  exp_din;
    logic [11:0] exp_cur;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int   base;
    int   cur;
    int   errs;
    int   first_bad;
    logic [7:0] ch;
    int   r;

    // ---- 1: reset state and full-screen clear --------------------------
    repeat (3) @(negedge wclk);
    chk("rst_write_en", write_en, 1'b0);
    chk("rst_waddr", waddr, 12'd0);
    chk("rst_din", din, 8'd0);
    chk("rst_cursor", cursor_addr, 12'd0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_s_ready", s_ready, 1'b0);

    base = la.size();
    rst = 1'b0;
    @(negedge wclk);
    chk("clr_first_we", write_en, 1'b1);
    chk("clr_first_addr", waddr, 12'd0);
    wait_idle();
    check_blank_run("clr_all", base, 0, CELLS);
    chk("clr_done_s_ready", s_ready, 1'b1);
    chk("clr_done_cursor", cursor_addr, 12'd0);

    // ---- 2: single-byte vector table, starting at cursor 0 -------------
    vecs.push_back('{8'h41, 1'b1, 12'd0, 8'h41, 12'd1});
    vecs.push_back('{8'h42, 1'b1, 12'd1, 8'h42, 12'd2});
    vecs.push_back('{8'h08, 1'b1, 12'd1, 8'h20, 12'd1});
    vecs.push_back('{8'h0D, 1'b0, 12'd0, 8'h00, 12'd0});
    vecs.push_back('{8'h08, 1'b0, 12'd0, 8'h00, 12'd0});
    vecs.push_back('{8'h7E, 1'b1, 12'd0, 8'h7E, 12'd1});
    vecs.push_back('{8'h01, 1'b0, 12'd0, 8'h00, 12'd1});
    vecs.push_back('{8'h7F, 1'b0, 12'd0, 8'h00, 12'd1});
    vecs.push_back('{8'hC8, 1'b0, 12'd0, 8'h00, 12'd1});
    vecs.push_back('{8'h20, 1'b1, 12'd1, 8'h20, 12'd2});
`ifdef TEXT_TAB_EN
    vecs.push_back('{8'h09, 1'b0, 12'd0, 8'h00, 12'd8});
`else
    vecs.push_back('{8'h09, 1'b0, 12'd0, 8'h00, 12'd2});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      send_byte(vecs[i].ch);
      $display("vec %0d: ch=0x%02h we=%b waddr=%0d din=0x%02h cursor=%0d",
               i, vecs[i].ch, write_en, waddr, din, cursor_addr);
      chk($sformatf("vec%0d_we", i), write_en, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d_addr", i), waddr, vecs[i].exp_addr);
        chk($sformatf("vec%0d_din", i), din, vecs[i].exp_din);
      end
      chk($sformatf("vec%0d_cursor", i), cursor_addr, vecs[i].exp_cur);
    end

    // ---- 3: 81 printables from home wrap into a cleared row 1 ----------
    send_byte(8'h0C);
    chk("ff_we", write_en, 1'b0);
    chk("ff_cursor", cursor_addr, 12'd0);
    wait_idle();
    for (int i = 0; i < COLS; i++) send_byte(8'(8'h61 + i % 26));
    chk("wrap80_we", write_en, 1'b1);
    chk("wrap80_addr", waddr, 12'd79);
    chk("wrap80_din", din, 8'(8'h61 + 79 % 26));
    chk("wrap80_s_ready", s_ready, 1'b0);
    chk("wrap80_cursor", cursor_addr, 12'd80);
    base = la.size();
    wait_idle();
    check_blank_run("row1_clear", base, 80, COLS);
    send_byte(8'h5A);
    chk("wrap81_addr", waddr, 12'd80);
    chk("wrap81_din", din, 8'h5A);
    chk("wrap81_cursor", cursor_addr, 12'd81);

    // ---- 4: LF from the last row wraps to row 0 ------------------------
    send_byte(8'h0D);
    for (int i = 0; i < ROWS - 2; i++) begin
      send_byte(8'h0A);
      wait_idle();
    end
    chk("row29_cursor", cursor_addr, 12'd2320);
    send_byte(8'h0A);
    chk("lf_wrap_cursor", cursor_addr, 12'd0);
    base = la.size();
    wait_idle();
    check_blank_run("row0_clear", base, 0, COLS);
    send_byte(8'h08);
    chk("bs_col0_we", write_en, 1'b0);
    chk("bs_col0_cursor", cursor_addr, 12'd0);

    // ---- 5: tab handling -----------------------------------------------
    for (int i = 0; i < 5; i++) send_byte(8'h54);
    send_byte(8'h09);
    chk("tab5_we", write_en, 1'b0);
`ifdef TEXT_TAB_EN
    chk("tab5_cursor", cursor_addr, 12'd8);
    cur = 8;
`else
    chk("tab5_cursor", cursor_addr, 12'd5);
    cur = 5;
`endif
    for (int i = cur; i < 78; i++) send_byte(8'h75);
    chk("col78_cursor", cursor_addr, 12'd78);
    send_byte(8'h09);
    chk("tab78_we", write_en, 1'b0);
`ifdef TEXT_TAB_EN
    chk("tab78_cursor", cursor_addr, 12'd80);
    base = la.size();
    wait_idle();
    check_blank_run("tab_row_clear", base, 80, COLS);
`else
    chk("tab78_cursor", cursor_addr, 12'd78);
`endif

    // ---- 6: reset in the middle of a full clear ------------------------
    send_byte(8'h0C);
    repeat (1000) @(negedge wclk);
    rst = 1'b1;
    @(negedge wclk);
    rst = 1'b0;
    chk("midrst_we", write_en, 1'b0);
    chk("midrst_busy", busy, 1'b1);
    chk("midrst_s_ready", s_ready, 1'b0);
    base = la.size();
    wait_idle();
    check_blank_run("midrst_clear", base, 0, CELLS);
    chk("midrst_cursor", cursor_addr, 12'd0);

    // ---- 7: randomized stream against the screen model -----------------
    send_byte(8'h0C);
    model_byte(8'h0C);
    wait_idle();
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      ch = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 77) ch = 8'h0D;
      else if (r < 82) ch = 8'h0A;
      else if (r < 90) ch = 8'h08;
      else if (r < 95) ch = 8'h09;
      else begin
        ch = 8'($urandom_range(0, 255));
        if (ch == 8'h0C) ch = 8'h00;
      end
      model_byte(ch);
      send_byte(ch);
      wait_idle();
      chk($sformatf("rand%0d_cursor(ch=0x%02h)", i, ch), cursor_addr, 32'(m_row * COLS + m_col));
    end
    errs = 0;
    first_bad = -1;
    for (int a = 0; a < CELLS; a++) begin
      if (dut_mem[a] !== scr[a]) begin
        if (first_bad < 0) first_bad = a;
        errs++;
      end
    end
    if (errs != 0)
      $display("screen first differing cell %0d: got 0x%02h, expected 0x%02h",
               first_bad, dut_mem[first_bad], scr[first_bad]);
    chk("rand_screen_cell_errors", errs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
